// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide unit.
//   div_code_t  : operation select as presented on DivCode
//   div_state_t : divider FSM state encoding
//   DIV0_QUO    : quotient returned for a zero divisor
//   INT_MIN     : most negative 32-bit value (signed-overflow detection)
//   neg32()     : two's complement negate
package div_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_code_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_t;

  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/mdu_divider_if.sv
// Handshake bundle between the EX stage (master) and the divide unit (slave).
//   start/DivCode/A/B : issue request, sampled when ready=1
//   flush             : pipeline kill
//   ready/busy        : issue-accept and stall indications
//   result_valid/result_ack/DivResult : result handshake
interface mdu_divider_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      DivCode;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            result_valid;
  logic            result_ack;
  logic [XLEN-1:0] DivResult;

  modport master (
    output start, DivCode, A, B, flush, result_ack,
    input  ready, busy, result_valid, DivResult
  );

  modport slave (
    input  start, DivCode, A, B, flush, result_ack,
    output ready, busy, result_valid, DivResult
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
//   rem, quo   : current partial remainder and dividend/quotient shift register
//   divisor    : unsigned divisor magnitude
//   rem_next   : partial remainder after this step
//   quo_next   : shift register with the new quotient bit in the LSB
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] rem_trial;

  // rem < divisor always holds, so the trial difference fits in XLEN+1 bits
  // and its MSB alone says whether the subtraction went negative.
  assign rem_shift = {rem, quo[XLEN-1]};
  assign rem_trial = rem_shift - {1'b0, divisor};
  assign quo_next  = {quo[XLEN-2:0], ~rem_trial[XLEN]};
  assign rem_next  = rem_trial[XLEN] ? rem_shift[XLEN-1:0] : rem_trial[XLEN-1:0];
endmodule

// File: rtl/mdu_divider.sv
// Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU), one quotient bit per clock.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of mdu_divider_if (issue, flush, result handshake)
// Flow: IDLE -> CALC (32 steps) -> FIX (sign/select) -> DONE (hold until ack).
module mdu_divider
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  mdu_divider_if.slave  bus
);
  div_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       code_reg;
  logic [XLEN-1:0]  divisor_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [XLEN-1:0]  quo_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic [XLEN-1:0]  result_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             valid_reg;

  logic            is_signed;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  // DIV and REM are the signed ops (DivCode[0]==0). INT_MIN has no positive
  // counterpart; its negation wraps back to 0x8000_0000, which is exactly the
  // unsigned magnitude 2^31 we need.
  assign is_signed = ~bus.DivCode[0];
  assign a_mag     = (is_signed && bus.A[XLEN-1]) ? neg32(bus.A) : bus.A;
  assign b_mag     = (is_signed && bus.B[XLEN-1]) ? neg32(bus.B) : bus.B;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      code_reg    <= 2'b00;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else if (bus.flush) begin
      // Kill beats start and ack; the last result stays on DivResult.
      state_reg <= S_IDLE;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            code_reg    <= bus.DivCode;
            divisor_reg <= b_mag;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
            if (bus.B == '0) begin
              // Zero divisor: fixed results, no sign fix-up.
              quo_reg    <= DIV0_QUO;
              rem_reg    <= bus.A;
              sign_q_reg <= 1'b0;
              sign_r_reg <= 1'b0;
              state_reg  <= S_FIX;
            end else if (is_signed && bus.A == INT_MIN && bus.B == DIV0_QUO) begin
              // INT_MIN / -1 overflows: fixed results, no sign fix-up.
              quo_reg    <= INT_MIN;
              rem_reg    <= '0;
              sign_q_reg <= 1'b0;
              sign_r_reg <= 1'b0;
              state_reg  <= S_FIX;
            end else begin
              quo_reg    <= a_mag;
              rem_reg    <= '0;
              sign_q_reg <= is_signed & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
              sign_r_reg <= is_signed & bus.A[XLEN-1];
              cnt_reg    <= '0;
              state_reg  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(XLEN - 1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (code_reg[1]) begin
            result_reg <= sign_r_reg ? neg32(rem_reg) : rem_reg;
          end else begin
            result_reg <= sign_q_reg ? neg32(quo_reg) : quo_reg;
          end
          busy_reg  <= 1'b0;
          valid_reg <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          if (bus.result_ack) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready        = ready_reg;
  assign bus.busy         = busy_reg;
  assign bus.result_valid = valid_reg;
  assign bus.DivResult    = result_reg;
endmodule
